// File: rtl/axi_sram_arbiter_pkg.sv
// Shared encodings for the two-requester SRAM-port arbiter: FSM states, owner ids and access size codes.
package axi_sram_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/axi_sram_arbiter_wstrb_gen.sv
// Combinational byte-strobe generator: maps access size and low address bits to a 4-lane strobe.
module wstrb_gen
    import axi_sram_arbiter_pkg::*;
(
    input  logic       wr,
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] strb
);

    always_comb begin
        strb = 4'b0000;
        if (wr) begin
            case (size)
                SIZE_BYTE: strb = 4'b0001 << addr_lo;
                SIZE_HALF: strb = 4'b0011 << {addr_lo[1], 1'b0};
                // size 3 is illegal and is treated as a full word
                default:   strb = 4'b1111;
            endcase
        end
    end

endmodule

// File: rtl/axi_sram_arbiter.sv
// Arbitrates the bridge's SRAM-like port between fetch and load/store, one transaction outstanding.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests instead of data-first.
module axi_sram_arbiter
    import axi_sram_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                bus_req,
    output logic                bus_wr,
    output logic [1:0]          bus_size,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wstrb,
    input  logic                bus_addr_ok,
    input  logic                bus_data_ok,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                stallreq_from_outside
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_t          state_reg, state_next;
    logic                owner_reg;
    logic                wr_reg;
    logic [1:0]          size_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [STRB_W-1:0]   wstrb_reg;

    logic                any_req;
    logic                grant_data;
    logic                data_first;
    logic                sel_wr;
    logic [1:0]          sel_size;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [3:0]          sel_strb;
    logic                in_idle, in_req, in_resp, resp_done;

`ifdef ARB_ROUND_ROBIN_EN
    logic                last_owner_reg;
    assign data_first = (last_owner_reg == OWN_INST);
`else
    assign data_first = 1'b1;
`endif

    assign in_idle    = (state_reg == ARB_IDLE);
    assign in_req     = (state_reg == ARB_REQ);
    assign in_resp    = (state_reg == ARB_RESP);
    assign resp_done  = in_resp & bus_data_ok;
    assign any_req    = inst_req | data_req;
    assign grant_data = data_req & (~inst_req | data_first);

    // Fetches are always word reads, so only the data port contributes wr/size/wdata.
    assign sel_wr    = grant_data ? data_wr    : 1'b0;
    assign sel_size  = grant_data ? data_size  : SIZE_WORD;
    assign sel_addr  = grant_data ? data_addr  : inst_addr;
    assign sel_wdata = grant_data ? data_wdata : '0;

    wstrb_gen u_wstrb_gen (
        .wr      (sel_wr),
        .size    (sel_size),
        .addr_lo (sel_addr[1:0]),
        .strb    (sel_strb)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_IDLE: if (any_req)     state_next = ARB_REQ;
            ARB_REQ:  if (bus_addr_ok) state_next = ARB_RESP;
            ARB_RESP: if (bus_data_ok) state_next = ARB_IDLE;
            default:                   state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= ARB_IDLE;
            owner_reg <= OWN_INST;
            wr_reg    <= 1'b0;
            size_reg  <= 2'd0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            wstrb_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (in_idle && any_req) begin
                owner_reg <= grant_data ? OWN_DATA : OWN_INST;
                wr_reg    <= sel_wr;
                size_reg  <= sel_size;
                addr_reg  <= sel_addr;
                wdata_reg <= sel_wdata;
                wstrb_reg <= STRB_W'(sel_strb);
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            last_owner_reg <= OWN_INST;
        else if (resp_done)
            last_owner_reg <= owner_reg;
    end
`endif

    // Input-driven outputs are masked by resetn so every output reads 0 while reset is held.
    assign inst_addr_ok = resetn & in_idle & any_req & ~grant_data;
    assign data_addr_ok = resetn & in_idle & grant_data;
    assign inst_data_ok = resetn & resp_done & (owner_reg == OWN_INST);
    assign data_data_ok = resetn & resp_done & (owner_reg == OWN_DATA);
    assign inst_rdata   = inst_data_ok ? bus_rdata : '0;
    assign data_rdata   = data_data_ok ? bus_rdata : '0;

    assign bus_req   = in_req;
    assign bus_wr    = wr_reg;
    assign bus_size  = size_reg;
    assign bus_addr  = addr_reg;
    assign bus_wdata = wdata_reg;
    assign bus_wstrb = wstrb_reg;

    assign stallreq_from_outside = resetn &
        ((in_idle & any_req) | in_req | (in_resp & ~bus_data_ok));

endmodule

// File: tb/tb_axi_sram_arbiter.sv
// Directed bench for axi_sram_arbiter: fetch, arbitration, store strobes, spurious data_ok and async reset.
module tb_axi_sram_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;
    logic        stall;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axi_sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk                   (clk),
        .resetn                (resetn),
        .inst_req              (inst_req),
        .inst_addr             (inst_addr),
        .inst_addr_ok          (inst_addr_ok),
        .inst_data_ok          (inst_data_ok),
        .inst_rdata            (inst_rdata),
        .data_req              (data_req),
        .data_wr               (data_wr),
        .data_size             (data_size),
        .data_addr             (data_addr),
        .data_wdata            (data_wdata),
        .data_addr_ok          (data_addr_ok),
        .data_data_ok          (data_data_ok),
        .data_rdata            (data_rdata),
        .bus_req               (bus_req),
        .bus_wr                (bus_wr),
        .bus_size              (bus_size),
        .bus_addr              (bus_addr),
        .bus_wdata             (bus_wdata),
        .bus_wstrb             (bus_wstrb),
        .bus_addr_ok           (bus_addr_ok),
        .bus_data_ok           (bus_data_ok),
        .bus_rdata             (bus_rdata),
        .stallreq_from_outside (stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  st_size [3] = '{2'd0, 2'd1, 2'd2};
    logic [31:0] st_addr [3] = '{32'h80000003, 32'h80000002, 32'h80000000};
    logic [31:0] st_wdat [3] = '{32'hAA000000, 32'hAABB0000, 32'h11223344};
    logic [3:0]  st_strb [3] = '{4'b1000, 4'b1100, 4'b1111};

    initial begin
        resetn = 1'b0; inst_req = 0; inst_addr = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;

        // reset state, with a request already pending
        cyc(); inst_req = 1; #1;
        check("rst_inst_addr_ok", 32'(inst_addr_ok), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_bus_req", 32'(bus_req), 0);
        cyc(); inst_req = 0; resetn = 1;

        // inst-only fetch with a spurious data_ok while in REQ
        cyc(); inst_req = 1; inst_addr = 32'hbfc00000; #1;
        check("t1_inst_addr_ok", 32'(inst_addr_ok), 1);
        check("t1_data_addr_ok", 32'(data_addr_ok), 0);
        check("t1_stall_idle", 32'(stall), 1);
        check("t1_bus_req_idle", 32'(bus_req), 0);
        cyc(); inst_req = 0; #1;
        check("t1_bus_req_r1", 32'(bus_req), 1);
        check("t1_bus_addr", bus_addr, 32'hbfc00000);
        check("t1_bus_size", 32'(bus_size), 2);
        check("t1_bus_wr", 32'(bus_wr), 0);
        check("t1_inst_addr_ok_r1", 32'(inst_addr_ok), 0);
        cyc(); bus_data_ok = 1; bus_rdata = 32'hdeadbeef; #1;
        check("t1_spurious_inst_data_ok", 32'(inst_data_ok), 0);
        check("t1_spurious_rdata", inst_rdata, 0);
        check("t1_bus_req_r2", 32'(bus_req), 1);
        cyc(); bus_data_ok = 0; bus_addr_ok = 1; #1;
        check("t1_bus_req_r3", 32'(bus_req), 1);
        cyc(); bus_addr_ok = 0; #1;
        check("t1_bus_req_resp", 32'(bus_req), 0);
        check("t1_stall_resp", 32'(stall), 1);
        cyc();
        cyc(); bus_data_ok = 1; bus_rdata = 32'h3c1d0001; #1;
        check("t1_inst_data_ok", 32'(inst_data_ok), 1);
        check("t1_inst_rdata", inst_rdata, 32'h3c1d0001);
        check("t1_data_rdata", data_rdata, 0);
        check("t1_stall_dataok", 32'(stall), 0);
        cyc(); bus_data_ok = 0; #1;
        check("t1_stall_after", 32'(stall), 0);
        check("t1_bus_req_after", 32'(bus_req), 0);

        // simultaneous inst and data requests: data wins, inst follows after the bubble
        inst_req = 1; inst_addr = 32'hbfc00004;
        data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h80001004; #1;
        check("t2_data_addr_ok", 32'(data_addr_ok), 1);
        check("t2_inst_addr_ok", 32'(inst_addr_ok), 0);
        cyc(); data_req = 0; bus_addr_ok = 1; #1;
        check("t2_bus_addr", bus_addr, 32'h80001004);
        check("t2_bus_wstrb", 32'(bus_wstrb), 0);
        check("t2_inst_waits", 32'(inst_addr_ok), 0);
        cyc(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h12345678; #1;
        check("t2_data_data_ok", 32'(data_data_ok), 1);
        check("t2_data_rdata", data_rdata, 32'h12345678);
        check("t2_inst_data_ok", 32'(inst_data_ok), 0);
        check("t2_inst_rdata", inst_rdata, 0);
        cyc(); bus_data_ok = 0; #1;
        check("t2_inst_granted", 32'(inst_addr_ok), 1);
        cyc(); inst_req = 0; bus_addr_ok = 1; #1;
        check("t2_inst_bus_addr", bus_addr, 32'hbfc00004);
        cyc(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h00000abc; #1;
        check("t2_inst_rdata2", inst_rdata, 32'h00000abc);

        // stores of each size and their strobes
        for (int i = 0; i < 3; i++) begin
            cyc(); bus_data_ok = 0; bus_rdata = 0;
            data_req = 1; data_wr = 1; data_size = st_size[i];
            data_addr = st_addr[i]; data_wdata = st_wdat[i]; #1;
            check($sformatf("t3_%0d_addr_ok", i), 32'(data_addr_ok), 1);
            cyc(); data_req = 0; bus_addr_ok = 1; #1;
            check($sformatf("t3_%0d_bus_wr", i), 32'(bus_wr), 1);
            check($sformatf("t3_%0d_bus_wstrb", i), 32'(bus_wstrb), 32'(st_strb[i]));
            check($sformatf("t3_%0d_bus_wdata", i), bus_wdata, st_wdat[i]);
            check($sformatf("t3_%0d_bus_size", i), 32'(bus_size), 32'(st_size[i]));
            check($sformatf("t3_%0d_bus_addr", i), bus_addr, st_addr[i]);
            cyc(); bus_addr_ok = 0; bus_data_ok = 1; #1;
            check($sformatf("t3_%0d_data_data_ok", i), 32'(data_data_ok), 1);
        end

        // asynchronous reset while in RESP, then a fresh fetch
        cyc(); bus_data_ok = 0; data_wr = 0; inst_req = 1; inst_addr = 32'hbfc00010; #1;
        check("t4_inst_addr_ok", 32'(inst_addr_ok), 1);
        cyc(); bus_addr_ok = 1;
        cyc(); bus_addr_ok = 0; #1;
        check("t4_stall_resp", 32'(stall), 1);
        resetn = 0; bus_data_ok = 1; bus_rdata = 32'h55555555; #1;
        check("t4_rst_inst_data_ok", 32'(inst_data_ok), 0);
        check("t4_rst_inst_rdata", inst_rdata, 0);
        check("t4_rst_inst_addr_ok", 32'(inst_addr_ok), 0);
        check("t4_rst_stall", 32'(stall), 0);
        check("t4_rst_bus_addr", bus_addr, 0);
        check("t4_rst_bus_req", 32'(bus_req), 0);
        cyc(); resetn = 1; bus_data_ok = 0; #1;
        check("t4_regrant", 32'(inst_addr_ok), 1);
        check("t4_regrant_stall", 32'(stall), 1);
        cyc(); inst_req = 0; #1;
        check("t4_bus_req", 32'(bus_req), 1);
        check("t4_bus_addr", bus_addr, 32'hbfc00010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_sram_arbiter.md
Name: axi_sram_arbiter

Overview:
- Shares the single SRAM-like port of the CPU core's external bus bridge between two requesters: the instruction fetch port and the data (load/store) port.
- Holds at most one transaction outstanding and routes each response back to the requester that issued it.
- Generates write strobes from the access size and address.
- Drives `stallreq_from_outside` into the pipeline control block, so the pipeline freezes while a memory access is unresolved.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  fetch request (read only)
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  fetch request accepted
- inst_data_ok  out  1  fetch data valid
- inst_rdata  out  DATA_W  fetch data
- data_req  in  1  data request
- data_wr  in  1  1 = store, 0 = load
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  store data, lane-aligned
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  load data valid / store complete
- data_rdata  out  DATA_W  load data
- bus_req  out  1  request to bridge
- bus_wr  out  1  bridge write flag
- bus_size  out  2  bridge size
- bus_addr  out  ADDR_W  bridge address
- bus_wdata  out  DATA_W  bridge write data
- bus_wstrb  out  DATA_W/8  byte strobes
- bus_addr_ok  in  1  bridge accepted request
- bus_data_ok  in  1  bridge response valid
- bus_rdata  in  DATA_W  bridge read data
- stallreq_from_outside  out  1  stall request to pipeline control

Behaviour:
- The state machine has three states: IDLE, REQ and RESP. An `owner` register records which requester holds the bus (0 = inst, 1 = data). Hold registers keep wr, size, addr, wdata and wstrb.
- Reset value of every output is 0. Reset returns the FSM to IDLE and clears `owner` and all hold registers. An access in flight is abandoned; the bridge is reset by the same signal.
- IDLE, with any request asserted:
  - Grant per priority. Default priority: data over inst.
  - Pulse the winner's `*_addr_ok` for one cycle, combinationally in that cycle.
  - Capture the winner's fields into the hold registers and go to REQ.
  - The loser sees `addr_ok` = 0 and must keep its request asserted.
- REQ:
  - `bus_req` = 1, and all `bus_*` fields come from the hold registers and stay stable.
  - On `bus_addr_ok`, go to RESP; otherwise stay.
- RESP:
  - `bus_req` = 0.
  - On `bus_data_ok`:
    - Drive the owner's `*_data_ok` = 1 combinationally for that cycle.
    - Drive `*_rdata` = `bus_rdata` to the owner only; the non-owner's rdata is 0.
    - Go to IDLE.
- `bus_data_ok` in IDLE or REQ is ignored, and no `*_data_ok` is raised.
- Latency:
  - Grant to `bus_req` is 1 cycle.
  - `bus_data_ok` to requester is 0 cycles.
  - There is a 1-cycle IDLE bubble between back-to-back transactions.
- Strobes:
  - Loads: `wstrb` = 0.
  - size 0: `4'b0001 << addr[1:0]`.
  - size 1: `4'b0011 << {addr[1],1'b0}`.
  - size 2: `4'b1111`.
  - size 3 is illegal; treat it as size 2.
- `bus_size` and `bus_addr` pass through unmodified. Fetches use size 2 and wr 0.
- `stallreq_from_outside` = (IDLE & (inst_req | data_req)) | REQ | (RESP & ~bus_data_ok). This is combinational and falls in the `data_ok` cycle.
- Simultaneous requests in IDLE are resolved by priority only; there is no starvation guard in the default build.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit `last_owner` register, reset 0 (inst), set when a transaction completes.
  - On simultaneous requests in IDLE, grant the requester that is not `last_owner`. A single requester is always granted.
- Undefined: fixed priority, data over inst, and no extra register.

Decomposition:
- Shared package/defines header holds the state encodings (ARB_IDLE = 2'd0, ARB_REQ = 2'd1, ARB_RESP = 2'd2), the owner encodings (OWN_INST = 1'b0, OWN_DATA = 1'b1) and the size codes.
- One sub-module: `wstrb_gen`, combinational, taking size and addr[1:0] and producing a 4-bit strobe.

Test Plan:
- Inst-only read at 0xbfc00000, bridge addr_ok after 2 cycles and data_ok after 3 more with rdata 0x3c1d0001 → one `inst_addr_ok` pulse, `bus_req` high for exactly 3 cycles, `inst_data_ok` = 1 with `inst_rdata` = 0x3c1d0001, stall low the next cycle.
- inst_req and data_req rise together (data load at 0x80001004) → data granted first; inst is granted in the IDLE cycle after `data_data_ok`. With ARB_ROUND_ROBIN_EN and `last_owner` = data, inst is granted first.
- Store byte at addr 0x80000003, wdata 0xAA000000 → `bus_wr` = 1, `bus_wstrb` = 4'b1000, `data_data_ok` on `bus_data_ok`. A half store at 0x80000002 gives 4'b1100; a word store gives 4'b1111.
- Spurious `bus_data_ok` while in REQ → ignored, no `*_data_ok`, FSM stays in REQ.
- `resetn` asserted low while in RESP → FSM goes to IDLE, all outputs 0 immediately (async). After release, a new inst request is granted normally.
